// File: rtl/switch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : switch_pkg
//  Purpose  : Shared switch-wide constants and types: port count, metadata
//             record width, the software-visible mailbox word layout and the
//             register word indices of the four mailbox words.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package switch_pkg;

  localparam int unsigned NUM_PORTS = 4;
  localparam int unsigned META_W    = 30;

  // Register word indices of interface_in_0..3 (addresses 1..4).
  localparam int unsigned c_WORD_IDX_IF_IN_0 = 1;
  localparam int unsigned c_WORD_IDX_IF_IN_1 = 2;
  localparam int unsigned c_WORD_IDX_IF_IN_2 = 3;
  localparam int unsigned c_WORD_IDX_IF_IN_3 = 4;

  // Mailbox word: bit31 valid, bit30 sticky dropped, bits29:0 head record.
  typedef struct packed {
    logic              valid;
    logic              dropped;
    logic [META_W-1:0] meta;
  } meta_word_t;

  // An empty mailbox reads all zeros, so the record field is masked when
  // there is nothing valid behind it.
  function automatic meta_word_t pack_word(input logic              valid,
                                           input logic              dropped,
                                           input logic [META_W-1:0] meta);
    meta_word_t w;
    w.valid   = valid;
    w.dropped = dropped;
    w.meta    = valid ? meta : '0;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/meta_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : meta_fifo
//  Purpose  : Single-port metadata FIFO with a sticky overflow flag.
//             A push while full (with no pop in the same cycle) discards the
//             record and sets dropped; any pop clears dropped.
//  Ports    : clk, reset          - clock, synchronous active-high reset
//             push, pop           - requests (pop ignored while empty)
//             din                 - record to push
//             dout                - head record (combinational read)
//             empty, full, count  - occupancy status, count in 0..DEPTH
//             dropped             - sticky overflow flag
//  Revision : 1.0  initial release
// ============================================================================
module meta_fifo #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned META_W = 30
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [META_W-1:0]          din,
  output logic [META_W-1:0]          dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       dropped
);

  localparam int unsigned c_PTR_W = $clog2(DEPTH);
  localparam int unsigned c_CNT_W = $clog2(DEPTH + 1);

  logic [META_W-1:0]  r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               r_dropped;

  logic w_empty;
  logic w_full;
  logic w_pop_ok;
  logic w_push_ok;
  logic w_drop;

  assign w_empty   = (r_count == c_CNT_W'(0));
  assign w_full    = (r_count == c_CNT_W'(DEPTH));
  assign w_pop_ok  = pop && !w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push_ok = push && (!w_full || w_pop_ok);
  assign w_drop    = push && w_full && !w_pop_ok;

  // Storage carries no reset; validity is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (w_push_ok && !reset) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_dropped <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
      // Drop has priority, though a pop always makes room so both never
      // coincide in practice.
      if (w_drop) begin
        r_dropped <= 1'b1;
      end else if (w_pop_ok) begin
        r_dropped <= 1'b0;
      end
    end
  end

  assign dout    = r_mem[r_rd_ptr];
  assign empty   = w_empty;
  assign full    = w_full;
  assign count   = r_count;
  assign dropped = r_dropped;

endmodule
`default_nettype wire

// File: rtl/egress_meta_mailbox.sv
`default_nettype none
// ============================================================================
//  Module   : egress_meta_mailbox
//  Purpose  : Per-port metadata mailbox between the four egress ports and the
//             software poll interface. One FIFO per port; the head is shown
//             combinationally as {valid, dropped, meta} and popped by a
//             one-cycle ack from the interface block.
//  Ports    : clk, reset           - clock, synchronous active-high reset
//             enable               - gate for accepting egress records
//             egress_valid[3:0]    - per-port record strobe
//             egress_meta[3:0]     - per-port 30-bit record
//             interface_out_ack    - per-port pop pulse
//             interface_in_0..3    - mailbox head words
//             meta_count[3:0]      - per-port occupancy (debug)
//  Revision : 1.0  initial release
// ============================================================================
module egress_meta_mailbox #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned META_W = switch_pkg::META_W
) (
  input  logic                                                 clk,
  input  logic                                                 reset,
  input  logic                                                 enable,
  input  logic [switch_pkg::NUM_PORTS-1:0]                     egress_valid,
  input  logic [switch_pkg::NUM_PORTS-1:0][META_W-1:0]         egress_meta,
  input  logic [switch_pkg::NUM_PORTS-1:0]                     interface_out_ack,
  output logic [31:0]                                          interface_in_0,
  output logic [31:0]                                          interface_in_1,
  output logic [31:0]                                          interface_in_2,
  output logic [31:0]                                          interface_in_3,
  output logic [switch_pkg::NUM_PORTS-1:0][$clog2(DEPTH+1)-1:0] meta_count
);

  import switch_pkg::*;

  meta_word_t w_word [NUM_PORTS];

  genvar n;
  generate
    for (n = 0; n < NUM_PORTS; n++) begin : g_port
      logic [META_W-1:0] w_dout;
      logic              w_empty;
      logic              w_full;
      logic              w_dropped;

      // With enable low, egress records are ignored outright and never
      // reach the FIFO, so they cannot register as drops either.
      meta_fifo #(
        .DEPTH  (DEPTH),
        .META_W (META_W)
      ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (enable && egress_valid[n]),
        .pop     (interface_out_ack[n]),
        .din     (egress_meta[n]),
        .dout    (w_dout),
        .empty   (w_empty),
        .full    (w_full),
        .count   (meta_count[n]),
        .dropped (w_dropped)
      );

      assign w_word[n] = pack_word(!w_empty, w_dropped, w_dout);
    end
  endgenerate

  assign interface_in_0 = w_word[0];
  assign interface_in_1 = w_word[1];
  assign interface_in_2 = w_word[2];
  assign interface_in_3 = w_word[3];

endmodule
`default_nettype wire

// File: tb/tb_egress_meta_mailbox.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_egress_meta_mailbox
//  Purpose  : Self-checking bench for egress_meta_mailbox: directed vector
//             table plus randomized traffic against a queue-based model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_egress_meta_mailbox;

  localparam int DEPTH = 8;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  enable = 1'b0;
  logic [3:0]            egress_valid = '0;
  logic [3:0][29:0]      egress_meta = '0;
  logic [3:0]            interface_out_ack = '0;
  logic [31:0]           interface_in_0, interface_in_1, interface_in_2, interface_in_3;
  logic [3:0][3:0]       meta_count;

  logic [31:0] w_if [4];
  assign w_if[0] = interface_in_0;
  assign w_if[1] = interface_in_1;
  assign w_if[2] = interface_in_2;
  assign w_if[3] = interface_in_3;

  always #5 clk = ~clk;

  egress_meta_mailbox #(.DEPTH(DEPTH), .META_W(30)) dut (
    .clk               (clk),
    .reset             (reset),
    .enable            (enable),
    .egress_valid      (egress_valid),
    .egress_meta       (egress_meta),
    .interface_out_ack (interface_out_ack),
    .interface_in_0    (interface_in_0),
    .interface_in_1    (interface_in_1),
    .interface_in_2    (interface_in_2),
    .interface_in_3    (interface_in_3),
    .meta_count        (meta_count)
  );

  // ---------------- reference model: one queue + sticky flag per port -------
  logic [29:0] mq [4][$];
  bit          mdrop [4];

  int n_vec  = 0;
  int n_miss = 0;

  function automatic logic [31:0] model_word(input int p);
    if (mq[p].size() == 0) return 32'h0;
    return {1'b1, mdrop[p], mq[p][0]};
  endfunction

  task automatic model_update(input logic r, input logic e, input logic [3:0] v,
                              input logic [3:0] a, input logic [3:0][29:0] m);
    for (int p = 0; p < 4; p++) begin
      if (r) begin
        mq[p].delete();
        mdrop[p] = 1'b0;
      end else begin
        bit had_room;
        bit popped;
        had_room = (mq[p].size() < DEPTH);
        popped   = a[p] && (mq[p].size() > 0);
        if (popped) begin
          void'(mq[p].pop_front());
          mdrop[p] = 1'b0;
        end
        if (e && v[p]) begin
          if (had_room || popped) mq[p].push_back(m[p]);
          else                    mdrop[p] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_model(input string tag);
    for (int p = 0; p < 4; p++) begin
      n_vec++;
      if (w_if[p] !== model_word(p) || meta_count[p] !== 4'(mq[p].size())) begin
        n_miss++;
        $display("FAIL %s port%0d: got word=%h cnt=%0d, expected word=%h cnt=%0d",
                 tag, p, w_if[p], meta_count[p], model_word(p), mq[p].size());
      end
    end
  endtask

  // Drive one cycle of inputs, advance past the edge, update model, check.
  task automatic step(input logic r, input logic e, input logic [3:0] v,
                      input logic [3:0] a, input logic [3:0][29:0] m, input string tag);
    reset = r; enable = e; egress_valid = v; interface_out_ack = a; egress_meta = m;
    @(posedge clk);
    model_update(r, e, v, a, m);
    #1;
    check_model(tag);
  endtask

  // ---------------- directed vector table ----------------------------------
  typedef struct {
    logic        rst;
    logic        en;
    logic [3:0]  vld;
    logic [3:0]  ack;
    logic [29:0] meta;
    int          port;
    logic [31:0] exp_word;
    logic [3:0]  exp_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic e, input logic [3:0] v, input logic [3:0] a,
                     input logic [29:0] m, input int p, input logic [31:0] w, input int c);
    vec_t t;
    t.rst = r; t.en = e; t.vld = v; t.ack = a; t.meta = m;
    t.port = p; t.exp_word = w; t.exp_cnt = 4'(c);
    tbl.push_back(t);
  endtask

  initial begin
    // 1: reset, idle, ack on empty port
    add(1, 0, 4'h0, 4'h0, 30'h0, 0, 32'h0, 0);
    add(0, 1, 4'h0, 4'h0, 30'h0, 3, 32'h0, 0);
    add(0, 1, 4'h0, 4'h2, 30'h0, 1, 32'h0, 0);
    // 2: single record on port 2, then ack
    add(0, 1, 4'h4, 4'h0, 30'h0ABCDEF, 2, 32'h80ABCDEF, 1);
    add(0, 1, 4'h0, 4'h4, 30'h0,       2, 32'h0,        0);
    // 3: overflow port 0 with 9 records, drain
    for (int i = 1; i <= 9; i++)
      add(0, 1, 4'h1, 4'h0, 30'(i), 0, (i <= 8) ? 32'h80000001 : 32'hC0000001, (i <= 8) ? i : 8);
    for (int j = 1; j <= 8; j++)
      add(0, 1, 4'h0, 4'h1, 30'h0, 0, (j < 8) ? (32'h80000001 + 32'(j)) : 32'h0, 8 - j);
    // 4: port 1 full, simultaneous push and ack
    for (int i = 0; i < 8; i++)
      add(0, 1, 4'h2, 4'h0, 30'h100 + 30'(i), 1, 32'h80000100, i + 1);
    add(0, 1, 4'h2, 4'h2, 30'h1FF, 1, 32'h80000101, 8);
    for (int j = 1; j <= 8; j++)
      add(0, 1, 4'h0, 4'h2, 30'h0, 1,
          (j <= 6) ? (32'h80000101 + 32'(j)) : ((j == 7) ? 32'h800001FF : 32'h0), 8 - j);
    // 5: enable low with all strobes
    for (int i = 0; i < 5; i++)
      add(0, 0, 4'hF, 4'h0, 30'h3FFFFFFF, i % 4, 32'h0, 0);
    // 6: port 3 with 5 entries, reset coincident with ack
    for (int i = 0; i < 5; i++)
      add(0, 1, 4'h8, 4'h0, 30'h30 + 30'(i), 3, 32'h80000030, i + 1);
    add(1, 1, 4'h0, 4'h8, 30'h0, 3, 32'h0, 0);
    add(0, 1, 4'h8, 4'h0, 30'h5, 3, 32'h80000005, 1);
  end

  // ---------------- main sequence ------------------------------------------
  initial begin
    #1;
    for (int k = 0; k < tbl.size(); k++) begin
      step(tbl[k].rst, tbl[k].en, tbl[k].vld, tbl[k].ack, {4{tbl[k].meta}}, "model");
      n_vec++;
      if (w_if[tbl[k].port] !== tbl[k].exp_word || meta_count[tbl[k].port] !== tbl[k].exp_cnt) begin
        n_miss++;
        $display("FAIL vec%0d port%0d: got word=%h cnt=%0d, expected word=%h cnt=%0d",
                 k, tbl[k].port, w_if[tbl[k].port], meta_count[tbl[k].port],
                 tbl[k].exp_word, tbl[k].exp_cnt);
      end
    end

    // Randomized traffic: sparse acks so FIFOs fill and overflow regularly.
    for (int c = 0; c < 600; c++) begin
      logic [3:0]       v, a;
      logic [3:0][29:0] m;
      logic             r, e;
      r = ($urandom_range(63) == 0);
      e = ($urandom_range(15) != 0);
      for (int p = 0; p < 4; p++) begin
        v[p] = ($urandom_range(1) == 1);
        a[p] = ($urandom_range(3) == 0);
        m[p] = 30'($urandom);
      end
      step(r, e, v, a, m, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
